mem_wb_stage: RTL
=================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameters SHALL be:
- CNT_W, default 32, width of the retired-instruction counter.
REQ-002 Ports SHALL be:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Enable  in  1  1 = pipeline advances this edge; 0 = stall, hold contents
- Flush  in  1  1 = load a bubble at this edge
- ValidIn  in  1  MEM stage holds a real instruction
- AluResult  in  32  ALU result from MEM stage
- MemData  in  32  raw aligned data-memory word
- PcPlus4  in  32  link address for JAL
- Rd  in  5  destination register index
- RegWrite  in  1  instruction writes the register file
- MemToReg  in  1  select load data for write-back
- Jal  in  1  select PcPlus4 for write-back
- LoadType  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu
- AddrLow  in  2  AluResult[1:0] of the load address
- WbData  out  32  register-file write data
- WbRd  out  5  register-file write index
- WbWe  out  1  register-file write enable
- WbValid  out  1  WB stage holds a real instruction
- InstrCount  out  CNT_W  retired-instruction count

Function
REQ-003 The block SHALL hold one pipeline register set containing all input fields from ValidIn through AddrLow.
REQ-004 Each rising Clock edge SHALL apply the first matching rule:
- Flush=1: valid and RegWrite cleared; other fields don't-care.
- Enable=1: all fields captured from the inputs.
- Otherwise: all fields hold.
REQ-005 Flush SHALL take priority over Enable; Flush with Enable=0 SHALL still insert a bubble.
REQ-006 Capture-to-output latency SHALL be exactly one cycle. WbData, WbRd, WbWe and WbValid SHALL be combinational from the registered fields only, with no path from the inputs.
REQ-007 WbValid SHALL equal the registered valid bit.
REQ-008 WbWe SHALL be 1 only when all hold: registered valid=1, RegWrite=1, Rd!=0.
REQ-009 WbRd SHALL equal the registered Rd.
REQ-010 WbData priority SHALL be:
- registered Jal=1: PcPlus4
- else MemToReg=1: extracted load data
- else: AluResult
REQ-011 Load extraction SHALL be:
- lw: MemData unchanged.
- lb/lbu: byte MemData[8*AddrLow+7 : 8*AddrLow]; lb sign-extended, lbu zero-extended.
- lh/lhu: halfword MemData[31:16] if AddrLow[1]=1, else MemData[15:0]; lh sign-extended, lhu zero-extended. AddrLow[0] is ignored.
- Codes 101-111: treated as lw.
REQ-012 InstrCount SHALL increment by 1 at every edge where Flush=0, Enable=1 and ValidIn=1, and SHALL hold otherwise.
REQ-013 InstrCount SHALL wrap modulo 2^CNT_W with no saturation and no flag.
REQ-014 Bubbles SHALL NOT write the register file, whatever the values of their other fields.

Reset
REQ-015 Reset=1 SHALL immediately clear, independent of Clock:
- all pipeline fields
- InstrCount
The outputs then read WbData=0, WbRd=0, WbWe=0, WbValid=0, InstrCount=0.
REQ-016 While Reset=1, the block SHALL ignore all clock edges.
REQ-017 On Reset deassertion, the block SHALL resume normally from the first rising edge with Reset=0.
REQ-018 Reset asserted mid-stall SHALL discard the held instruction.

Verification
REQ-019 Each scenario below SHALL be covered by a directed bench test.
- Capture and ALU path: AluResult=0x0000_1234, Rd=5, RegWrite=1, ValidIn=1, Enable=1, one edge -> WbData=0x0000_1234, WbRd=5, WbWe=1, InstrCount=1.
- Load extraction: MemData=0x80FF_7F01, MemToReg=1 ->
  - lb, AddrLow=2: WbData=0xFFFF_FFFF
  - lbu, AddrLow=3: WbData=0x0000_0080
  - lh, AddrLow=0: WbData=0x0000_7F01
  - lhu, AddrLow=2: WbData=0x0000_80FF
- JAL priority: Jal=1, MemToReg=1, PcPlus4=0x0000_0044, Rd=1 -> WbData=0x0000_0044, WbWe=1.
- x0 and stall: Rd=0, RegWrite=1 -> WbWe=0. Then Enable=0 for 3 edges with changing inputs -> outputs and InstrCount unchanged.
- Flush priority: Flush=1 and Enable=1 with ValidIn=1 -> WbValid=0, WbWe=0, InstrCount unchanged.
- Reset and wrap: CNT_W=4, 16 valid captures -> InstrCount=0. Reset pulsed between edges -> all outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load-data extraction and write-back mux.
// Also counts retired instructions as they are captured into write-back.
module mem_wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Flush,
  input  logic             ValidIn,
  input  logic [31:0]      AluResult,
  input  logic [31:0]      MemData,
  input  logic [31:0]      PcPlus4,
  input  logic [4:0]       Rd,
  input  logic             RegWrite,
  input  logic             MemToReg,
  input  logic             Jal,
  input  logic [2:0]       LoadType,
  input  logic [1:0]       AddrLow,
  output logic [31:0]      WbData,
  output logic [4:0]       WbRd,
  output logic             WbWe,
  output logic             WbValid,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_BU = 3'b010,
    LD_H  = 3'b011,
    LD_HU = 3'b100
  } load_type_e;

  logic             r_valid;
  logic [31:0]      r_alu_result;
  logic [31:0]      r_mem_data;
  logic [31:0]      r_pc_plus4;
  logic [4:0]       r_rd;
  logic             r_reg_write;
  logic             r_mem_to_reg;
  logic             r_jal;
  logic [2:0]       r_load_type;
  logic [1:0]       r_addr_low;
  logic [CNT_W-1:0] r_instr_count;

  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load_data;

  // A flush only needs to kill valid and RegWrite; the payload may keep
  // whatever it held, since a bubble can never reach the register file.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_valid       <= 1'b0;
      r_alu_result  <= '0;
      r_mem_data    <= '0;
      r_pc_plus4    <= '0;
      r_rd          <= '0;
      r_reg_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_jal         <= 1'b0;
      r_load_type   <= '0;
      r_addr_low    <= '0;
      r_instr_count <= '0;
    end else if (Flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (Enable) begin
      r_valid       <= ValidIn;
      r_alu_result  <= AluResult;
      r_mem_data    <= MemData;
      r_pc_plus4    <= PcPlus4;
      r_rd          <= Rd;
      r_reg_write   <= RegWrite;
      r_mem_to_reg  <= MemToReg;
      r_jal         <= Jal;
      r_load_type   <= LoadType;
      r_addr_low    <= AddrLow;
      if (ValidIn) r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statements can leave a value unassigned and infer a latch.
  always_comb begin
    w_byte = r_mem_data[7:0];
    case (r_addr_low)
      2'd1:    w_byte = r_mem_data[15:8];
      2'd2:    w_byte = r_mem_data[23:16];
      2'd3:    w_byte = r_mem_data[31:24];
      default: w_byte = r_mem_data[7:0];
    endcase

    w_half = r_addr_low[1] ? r_mem_data[31:16] : r_mem_data[15:0];

    // Unassigned codes fall through to a full-word load.
    w_load_data = r_mem_data;
    case (load_type_e'(r_load_type))
      LD_B:    w_load_data = {{24{w_byte[7]}}, w_byte};
      LD_BU:   w_load_data = {24'd0, w_byte};
      LD_H:    w_load_data = {{16{w_half[15]}}, w_half};
      LD_HU:   w_load_data = {16'd0, w_half};
      default: w_load_data = r_mem_data;
    endcase
  end

  assign WbData     = r_jal ? r_pc_plus4 : (r_mem_to_reg ? w_load_data : r_alu_result);
  assign WbRd       = r_rd;
  assign WbWe       = r_valid & r_reg_write & (r_rd != 5'd0);
  assign WbValid    = r_valid;
  assign InstrCount = r_instr_count;

endmodule
